// File: rtl/arb_mux_n.sv
// arb_mux_n: registered CH-way valid/ready arbiter-mux.
// Round-robin or fixed-priority grant feeding one output register.
module arb_mux_n #(
  parameter int N  = 32,
  parameter int CH = 4,
  parameter bit RR = 1'b1,
  localparam int SELW = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     in_valid,
  input  logic [CH*N-1:0]   in_data,
  output logic [CH-1:0]     in_ready,
  output logic              out_valid,
  output logic [N-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready
);

  logic            load;
  logic            gnt_any;
  logic [SELW-1:0] gnt_idx;
  logic [SELW-1:0] sel;
  logic            grant;
  int              idx;

  logic [SELW-1:0] last_q, last_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;

  // Search starts one past the last winner and wraps; RR=0 starts at 0.
  always_comb begin
    load    = !out_valid_q || out_ready;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sel     = '0;
    idx     = 0;
    for (int k = 0; k < CH; k++) begin
      idx = RR ? (int'(last_q) + 1 + k) % CH : k;
      sel = SELW'(idx);
      if (!gnt_any && in_valid[sel]) begin
        gnt_any = 1'b1;
        gnt_idx = sel;
      end
    end
    grant = rst_n && load && gnt_any;
  end

  always_comb begin
    in_ready = '0;
    if (grant) in_ready = CH'(1) << gnt_idx;
  end

  always_comb begin
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (load) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = in_data[int'(gnt_idx)*N +: N];
        out_ch_d   = gnt_idx;
        if (RR) last_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q      <= SELW'(CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: random + directed check of RR and fixed-priority
// arb_mux_n against a queue-free behavioural model.
module tb_arb_mux_n;

  localparam int N  = 32;
  localparam int CH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     in_valid;
  logic [CH*N-1:0]   in_data;
  logic              out_ready;

  logic [CH-1:0]     rdy_rr, rdy_fp;
  logic              ov_rr, ov_fp;
  logic [N-1:0]      od_rr, od_fp;
  logic [1:0]        oc_rr, oc_fp;

  int n_chk = 0;
  int n_err = 0;

  logic [N-1:0] word [CH];

  // model state per mode: index 0 = fixed priority, 1 = round-robin
  bit           m_v  [2];
  logic [N-1:0] m_d  [2];
  int           m_c  [2];
  int           m_l  [2];

  logic [CH-1:0] obs_rdy [2];

  always #5 clk = ~clk;

  arb_mux_n #(.N(N), .CH(CH), .RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_rr),
    .out_valid(ov_rr), .out_data(od_rr), .out_ch(oc_rr),
    .out_ready(out_ready)
  );

  arb_mux_n #(.N(N), .CH(CH), .RR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_fp),
    .out_valid(ov_fp), .out_data(od_fp), .out_ch(oc_fp),
    .out_ready(out_ready)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [CH-1:0] v,
                              input int last, input bit rr);
    for (int k = 0; k < CH; k++) begin
      int c;
      c = rr ? (last + 1 + k) % CH : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [CH-1:0] exp_rdy(input int m,
                                            input logic [CH-1:0] v,
                                            input bit ordy, input bit rst);
    int g;
    logic [CH-1:0] r;
    r = '0;
    g = pick(v, m_l[m], m == 1);
    if (rst && (!m_v[m] || ordy) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_v[m] = 1'b0;
      m_d[m] = '0;
      m_c[m] = 0;
      m_l[m] = CH - 1;
    end
  endtask

  // Called from a negedge: apply inputs, compare, then advance one clock.
  task automatic cycle(input logic [CH-1:0] v,
                       input bit ordy, input bit rst);
    logic [CH-1:0] er [2];
    in_valid  = v;
    out_ready = ordy;
    rst_n     = rst;
    for (int i = 0; i < CH; i++) in_data[i*N +: N] = word[i];
    #1;
    for (int m = 0; m < 2; m++) er[m] = exp_rdy(m, v, ordy, rst);
    obs_rdy[0] = rdy_fp;
    obs_rdy[1] = rdy_rr;
    check("rr_ready", 32'(rdy_rr), 32'(er[1]));
    check("rr_valid", 32'(ov_rr), 32'(m_v[1]));
    check("rr_data", od_rr, m_d[1]);
    check("rr_ch", 32'(oc_rr), 32'(m_c[1]));
    check("fp_ready", 32'(rdy_fp), 32'(er[0]));
    check("fp_valid", 32'(ov_fp), 32'(m_v[0]));
    check("fp_data", od_fp, m_d[0]);
    check("fp_ch", 32'(oc_fp), 32'(m_c[0]));
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      for (int m = 0; m < 2; m++) begin
        int g;
        g = pick(v, m_l[m], m == 1);
        if (!m_v[m] || ordy) begin
          if (g >= 0) begin
            m_v[m] = 1'b1;
            m_d[m] = word[g];
            m_c[m] = g;
            if (m == 1) m_l[m] = g;
          end else begin
            m_v[m] = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '1;
    out_ready = 1'b1;
    in_data   = '0;
    for (int i = 0; i < CH; i++) word[i] = 32'hA000_0000 + 32'(i);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset held with all channels requesting
    repeat (2) cycle(4'hF, 1'b1, 1'b0);
    check("rst_out_valid", 32'(ov_rr), 32'h0);
    check("rst_out_data", od_rr, 32'h0);

    // release: channel 0 wins in both modes
    cycle(4'hF, 1'b1, 1'b1);
    check("rel_rr_ready", 32'(obs_rdy[1]), 32'h1);
    check("rel_fp_ready", 32'(obs_rdy[0]), 32'h1);

    // round-robin rotation, all channels busy
    repeat (8) cycle(4'hF, 1'b1, 1'b1);

    // fixed-priority picks 1 then 3 once 1 drops
    repeat (4) cycle(4'b1010, 1'b1, 1'b1);
    check("fp_ch1", 32'(oc_fp), 32'h1);
    cycle(4'b1000, 1'b1, 1'b1);
    check("fp_ch3", 32'(oc_fp), 32'h3);

    // backpressure for 3 cycles then resume
    cycle(4'hF, 1'b1, 1'b1);
    repeat (3) cycle(4'hF, 1'b0, 1'b1);
    repeat (2) cycle(4'hF, 1'b1, 1'b1);

    // sparse single pulse on channel 2
    repeat (2) cycle(4'h0, 1'b1, 1'b1);
    word[2] = 32'hDEAD_BEEF;
    cycle(4'b0100, 1'b1, 1'b1);
    check("sparse_ready", 32'(obs_rdy[1]), 32'h4);
    check("sparse_data", od_rr, 32'hDEAD_BEEF);
    check("sparse_ch", 32'(oc_rr), 32'h2);
    cycle(4'h0, 1'b1, 1'b1);
    check("sparse_drain", 32'(ov_rr), 32'h0);

    // reset while output is full and stalled
    cycle(4'hF, 1'b1, 1'b1);
    cycle(4'hF, 1'b0, 1'b0);
    check("midrst_valid", 32'(ov_rr), 32'h0);
    cycle(4'b0110, 1'b1, 1'b1);
    check("midrst_ready", 32'(obs_rdy[1]), 32'h2);
    cycle(4'h0, 1'b1, 1'b1);

    // random traffic, backpressure and occasional reset
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < CH; i++) word[i] = $urandom;
      cycle(CH'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 49) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
